// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: runs the 1-bit shifter once per cycle for
// 'amount' steps, then reports result and last bit shifted out with a done pulse.

module shift_sequencer_shifter (
  input  logic [15:0] in_i,
  input  logic [1:0]  shift_i,
  output logic [15:0] sout_o
);
  always_comb begin
    case (shift_i)
      2'b01:   sout_o = {in_i[14:0], 1'b0};
      2'b10:   sout_o = {1'b0, in_i[15:1]};
      2'b11:   sout_o = {in_i[15], in_i[15:1]};
      default: sout_o = in_i;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      in_val,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic             carry_out
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [15:0]      work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             cry_q, cry_d;
  logic [15:0]      result_q, result_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [1:0]       shift_op;
  logic [15:0]      sout;

  assign shift_op = (state_q == SHIFT) ? op_q : 2'b00;

  shift_sequencer_shifter u_shifter (
    .in_i    (work_q),
    .shift_i (shift_op),
    .sout_o  (sout)
  );

  // The done pulse cycle sits in IDLE; hold off acceptance until it has passed.
  assign ready     = (state_q == IDLE) && !done_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cry_d    = cry_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && ready) begin
          work_d  = in_val;
          op_d    = op;
          cnt_d   = amount;
          cry_d   = 1'b0;
          state_d = ((amount == '0) || (op == 2'b00)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = sout;
        cry_d  = (op_q == 2'b01) ? work_q[15] : work_q[0];
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_d   = 1'b1;
        result_d = work_q;
        carry_d  = cry_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      cry_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cry_q    <= cry_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, busy span, result/carry,
// ignored requests during SHIFT/DONE, and reset mid-shift.

module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] in_val;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic        ready, busy, done, carry_out;
  logic [15:0] result;

  int vectors = 0;
  int miscompares = 0;

  shift_sequencer #(.AMT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_val    (in_val),
    .op        (op),
    .amount    (amount),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Issue one request and follow it to its done pulse.
  task automatic run(input string tag, input logic [15:0] v, input logic [1:0] o,
                     input logic [3:0] n, input logic [15:0] exp_res,
                     input logic exp_cry, input int exp_lat, input int exp_busy);
    int k;
    int nbusy;
    in_val = v; op = o; amount = n; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; nbusy = 0;
    while (!done && k < 40) begin
      nbusy += busy;
      tick();
      k++;
    end
    chk({tag, "_latency"}, 16'(k), 16'(exp_lat));
    chk({tag, "_busy_cycles"}, 16'(nbusy), 16'(exp_busy));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_carry"}, 16'(carry_out), 16'(exp_cry));
    tick();
    chk({tag, "_done_1cycle"}, 16'(done), 16'd0);
    chk({tag, "_ready_after"}, 16'(ready), 16'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_val = '0; op = '0; amount = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_carry", 16'(carry_out), 16'd0);

    run("lsl4",  16'h0001, 2'b01, 4'd4,  16'h0010, 1'b0, 5, 4);
    run("lsr1",  16'h8001, 2'b10, 4'd1,  16'h4000, 1'b1, 2, 1);
    run("asr15n", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 16, 15);
    run("asr15p", 16'h7FFF, 2'b11, 4'd15, 16'h0000, 1'b1, 16, 15);
    run("amt0",  16'hABCD, 2'b01, 4'd0,  16'hABCD, 1'b0, 1, 0);
    run("pass9", 16'hABCD, 2'b00, 4'd9,  16'hABCD, 1'b0, 1, 0);

    // Requests during SHIFT and DONE must be ignored.
    in_val = 16'h00F0; op = 2'b10; amount = 4'd4; start = 1'b1;
    tick();
    start = 1'b1; in_val = 16'hFFFF; op = 2'b01; amount = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("ign_in_done_state_busy", 16'(busy), 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_result", result, 16'h000F);
    chk("ign_carry", 16'(carry_out), 16'd0);
    begin
      int extra = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        extra += done + busy;
      end
      chk("ign_no_second_job", 16'(extra), 16'd0);
    end
    chk("ign_result_held", result, 16'h000F);

    // Reset in the 3rd SHIFT cycle of an amount=8 request.
    in_val = 16'h0001; op = 2'b01; amount = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_busy_before_rst", 16'(busy), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", 16'(ready), 16'd1);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_done", 16'(done), 16'd0);
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_carry", 16'(carry_out), 16'd0);
    begin
      int extra = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        extra += done + busy;
      end
      chk("mid_rst_no_done", 16'(extra), 16'd0);
    end
    run("fresh", 16'h8001, 2'b01, 4'd1, 16'h0002, 1'b1, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
